mgt_01_sb_reg_file: RTL and testbench
=====================================

MGT_01_SB_REG_FILE -- requirements
Module: MGT_01_sb_reg_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, the register count; AW = $clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD_PORTS, default 3, the number of combinational read ports (3 serves FMA operands).
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 hardwires register 0 to zero (integer file), 0 makes it an ordinary register (float file).
REQ-005 SHALL have parameter BYPASS, default 1; 1 enables same-cycle write-to-read forwarding.
REQ-006 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit, reset, synchronous and active-high.
REQ-008 SHALL have port we_i, input, 1 bit, the writeback enable.
REQ-009 SHALL have port w_addr_i, input, AW bits, the writeback address.
REQ-010 SHALL have port wr_data_i, input, DATA_WIDTH bits, the writeback data.
REQ-011 SHALL have port r_addr_i, input, NUM_RD_PORTS x AW bits, the read addresses.
REQ-012 SHALL have port r_data_o, output, NUM_RD_PORTS x DATA_WIDTH bits, the read data.
REQ-013 SHALL have port r_busy_o, output, NUM_RD_PORTS bits; a set bit means the operand has a pending write.
REQ-014 SHALL have port issue_valid_i, input, 1 bit, the issue request that marks a destination pending.
REQ-015 SHALL have port issue_addr_i, input, AW bits, the issuing destination.
REQ-016 SHALL have port issue_ready_o, output, 1 bit, the issue accept.
REQ-017 SHALL have port busy_cnt_o, output, $clog2(NUM_REGS+1) bits, the number of pending registers.

Function
REQ-018 SHALL hold state as regs[NUM_REGS] of DATA_WIDTH bits plus a busy[NUM_REGS] bit vector.
REQ-019 SHALL write wr_data_i to regs[w_addr_i] and clear busy[w_addr_i] at the edge when we_i=1.
REQ-020 SHALL perform writes regardless of the busy bit; writeback to a non-busy register stores data and leaves busy at 0.
REQ-021 SHALL drive r_data_o[p] = regs[r_addr_i[p]] combinationally, with 0 cycles latency.
REQ-022 SHALL, with BYPASS=1 and we_i=1 and w_addr_i==r_addr_i[p], drive r_data_o[p]=wr_data_i and r_busy_o[p]=0 in the same cycle.
REQ-023 SHALL, with BYPASS=0, return the old value and old busy bit until the cycle after the edge.
REQ-024 SHALL drive r_busy_o[p] = busy[r_addr_i[p]] when not bypassed.
REQ-025 SHALL drive issue_ready_o = ~busy[issue_addr_i] (registered busy only; a same-cycle writeback does not raise ready).
REQ-026 SHALL treat an issue as accepted when issue_valid_i && issue_ready_o, setting busy[issue_addr_i] at the edge.
REQ-027 SHALL ignore issue_valid_i with issue_ready_o=0; the requester holds and retries.
REQ-028 SHALL, on accepted issue and writeback to the same address in one cycle, store the data and leave busy=1 (issue wins).
REQ-029 SHALL, with ZERO_REG=1, read register 0 as 0 and busy 0 always, ignore writes to it, keep issue_ready_o=1 for it, and never set its busy bit.
REQ-030 SHALL, with ZERO_REG=1, not bypass to register 0 (a read of register 0 returns 0 even when written).
REQ-031 SHALL drive busy_cnt_o = popcount(busy) combinationally from registered state, ranging 0..NUM_REGS.
REQ-032 SHALL service all read ports independently; identical addresses on several ports return identical data.

Reset
REQ-033 SHALL, on rst_i=1 at an edge, clear all regs to 0 and all busy bits to 0.
REQ-034 SHALL give rst_i priority over we_i and issue in the same cycle.
REQ-035 SHALL force r_data_o=0, r_busy_o=0, issue_ready_o=0 and busy_cnt_o=0 while rst_i=1.
REQ-036 SHALL apply reset mid-operation identically, dropping pending writes and issues.

Verification
REQ-037 SHALL verify: we=1, w_addr=0, data=500, ZERO_REG=1 -> read of addr 0 gives 0 on all ports, both in the same cycle and the next.
REQ-038 SHALL verify: we=1, addr 1, data=1000, then next cycle we=1, addr 1, data=2000 with r_addr[0]=1 -> BYPASS=1 gives 2000 that cycle; BYPASS=0 gives 1000 then 2000.
REQ-039 SHALL verify: issue addr 5 -> next cycle r_busy=1 for addr 5, busy_cnt=1, issue_ready=0 for addr 5; re-issue ignored; writeback 77 to addr 5 -> bypass shows 77, busy 0; next cycle busy_cnt=0.
REQ-040 SHALL verify: same-cycle accepted issue to addr 3 and writeback 9 to addr 3 -> next cycle regs[3]=9, busy[3]=1, busy_cnt=1.
REQ-041 SHALL verify: issue addrs 1..31 over 31 cycles -> busy_cnt=31; then rst_i=1 for one cycle with we=1 -> all outputs 0 during reset; after reset all regs read 0 and busy_cnt=0.
REQ-042 SHALL verify: we=0, addr 1, data 200 after addr 1 holds 2000 -> addr 1 still reads 2000.

Source files
------------

// File: rtl/mgt_01_sb_reg_file.sv
// Register file with per-register scoreboard busy bits, combinational multi-port reads,
// optional hardwired zero register and optional same-cycle writeback forwarding.
module mgt_01_sb_reg_file #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 3,
    parameter int ZERO_REG     = 1,
    parameter int BYPASS       = 1,
    localparam int AW          = $clog2(NUM_REGS),
    localparam int CW          = $clog2(NUM_REGS + 1)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     we_i,
    input  logic [AW-1:0]                            w_addr_i,
    input  logic [DATA_WIDTH-1:0]                    wr_data_i,
    input  logic [NUM_RD_PORTS-1:0][AW-1:0]          r_addr_i,
    output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]  r_data_o,
    output logic [NUM_RD_PORTS-1:0]                  r_busy_o,
    input  logic                                     issue_valid_i,
    input  logic [AW-1:0]                            issue_addr_i,
    output logic                                     issue_ready_o,
    output logic [CW-1:0]                            busy_cnt_o
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic                  w_is_zero;
    logic                  issue_is_zero;
    logic                  issue_accept;

    assign w_is_zero     = (ZERO_REG != 0) && (w_addr_i == '0);
    assign issue_is_zero = (ZERO_REG != 0) && (issue_addr_i == '0);

    // Issue handshake: a destination is marked pending only on the edge where
    // issue_valid_i && issue_ready_o; a stalled requester holds valid and its
    // address until ready rises. Ready looks at registered busy only.
    always_comb begin
        issue_ready_o = 1'b0;
        if (!rst_i) begin
            issue_ready_o = issue_is_zero ? 1'b1 : ~busy[issue_addr_i];
        end
    end

    assign issue_accept = issue_valid_i && issue_ready_o;

    // Issue is applied after writeback so a same-cycle pair leaves the register pending.
    always_comb begin
        busy_next = busy;
        if (we_i) begin
            busy_next[w_addr_i] = 1'b0;
        end
        if (issue_accept && !issue_is_zero) begin
            busy_next[issue_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (we_i && !w_is_zero) begin
                regs[w_addr_i] <= wr_data_i;
            end
            busy <= busy_next;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            r_data_o[p] = regs[r_addr_i[p]];
            r_busy_o[p] = busy[r_addr_i[p]];
            if ((BYPASS != 0) && we_i && (w_addr_i == r_addr_i[p])) begin
                r_data_o[p] = wr_data_i;
                r_busy_o[p] = 1'b0;
            end
            // Zero register wins over forwarding.
            if ((ZERO_REG != 0) && (r_addr_i[p] == '0)) begin
                r_data_o[p] = '0;
                r_busy_o[p] = 1'b0;
            end
            if (rst_i) begin
                r_data_o[p] = '0;
                r_busy_o[p] = 1'b0;
            end
        end
    end

    always_comb begin
        busy_cnt_o = '0;
        if (!rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                busy_cnt_o = busy_cnt_o + CW'(busy[i]);
            end
        end
    end

endmodule

// File: tb/tb_mgt_01_sb_reg_file.sv
// Directed bench: a forwarding and a non-forwarding instance share stimulus; a vector
// table covers the single-cycle cases, hand sequences cover fill-up and reset.
module tb_mgt_01_sb_reg_file;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int NP = 3;
    localparam int AW = 5;
    localparam int CW = 6;

    logic                   clk;
    logic                   rst;
    logic                   we;
    logic [AW-1:0]          w_addr;
    logic [DW-1:0]          wr_data;
    logic [NP-1:0][AW-1:0]  r_addr;
    logic                   issue_valid;
    logic [AW-1:0]          issue_addr;

    logic [NP-1:0][DW-1:0]  byp_data, nob_data;
    logic [NP-1:0]          byp_busy, nob_busy;
    logic                   byp_ready, nob_ready;
    logic [CW-1:0]          byp_cnt, nob_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [CW-1:0] exp_q[$];

    mgt_01_sb_reg_file #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NP),
                         .ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk_i(clk), .rst_i(rst), .we_i(we), .w_addr_i(w_addr), .wr_data_i(wr_data),
        .r_addr_i(r_addr), .r_data_o(byp_data), .r_busy_o(byp_busy),
        .issue_valid_i(issue_valid), .issue_addr_i(issue_addr),
        .issue_ready_o(byp_ready), .busy_cnt_o(byp_cnt)
    );

    mgt_01_sb_reg_file #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NP),
                         .ZERO_REG(1), .BYPASS(0)) u_nob (
        .clk_i(clk), .rst_i(rst), .we_i(we), .w_addr_i(w_addr), .wr_data_i(wr_data),
        .r_addr_i(r_addr), .r_data_o(nob_data), .r_busy_o(nob_busy),
        .issue_valid_i(issue_valid), .issue_addr_i(issue_addr),
        .issue_ready_o(nob_ready), .busy_cnt_o(nob_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int rst, we, wa, wd, iv, ia, ra0, ra12;
        int d0, b0, nd0, nb0, d12, rdy, cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int r, input int w, input int wa, input int wd,
                         input int iv, input int ia, input int ra0, input int ra12);
        rst         = r[0];
        we          = w[0];
        w_addr      = AW'(wa);
        wr_data     = DW'(wd);
        issue_valid = iv[0];
        issue_addr  = AW'(ia);
        r_addr[0]   = AW'(ra0);
        r_addr[1]   = AW'(ra12);
        r_addr[2]   = AW'(ra12);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1,1,1,55,1,2,1,1,     0,0,0,0,0,0,0};
        vecs[1]  = '{0,1,0,500,0,0,0,0,    0,0,0,0,0,1,0};
        vecs[2]  = '{0,0,0,0,0,0,0,0,      0,0,0,0,0,1,0};
        vecs[3]  = '{0,1,1,1000,0,0,1,0,   1000,0,0,0,0,1,0};
        vecs[4]  = '{0,1,1,2000,0,0,1,1,   2000,0,1000,0,2000,1,0};
        vecs[5]  = '{0,0,1,200,0,0,1,1,    2000,0,2000,0,2000,1,0};
        vecs[6]  = '{0,0,0,0,1,5,5,1,      0,0,0,0,2000,1,0};
        vecs[7]  = '{0,0,0,0,1,5,5,1,      0,1,0,1,2000,0,1};
        vecs[8]  = '{0,1,5,77,0,5,5,1,     77,0,0,1,2000,0,1};
        vecs[9]  = '{0,0,0,0,0,5,5,1,      77,0,77,0,2000,1,0};
        vecs[10] = '{0,1,3,9,1,3,3,1,      9,0,0,0,2000,1,0};
        vecs[11] = '{0,0,0,0,0,3,3,1,      9,1,9,1,2000,0,1};
        vecs[12] = '{0,0,0,0,1,0,0,1,      0,0,0,0,2000,1,1};
        vecs[13] = '{0,0,0,0,0,0,0,1,      0,0,0,0,2000,1,1};
        vecs[14] = '{0,1,3,10,0,3,3,1,     10,0,9,1,2000,0,1};
        vecs[15] = '{0,0,0,0,0,3,3,1,      10,0,10,0,2000,1,0};

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        // table: inputs applied, combinational outputs checked, then the edge commits
        for (int v = 0; v < 16; v++) begin
            drive(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd,
                  vecs[v].iv, vecs[v].ia, vecs[v].ra0, vecs[v].ra12);
            #2;
            check($sformatf("v%0d byp_data0", v), int'(byp_data[0]), vecs[v].d0);
            check($sformatf("v%0d byp_busy0", v), int'(byp_busy[0]), vecs[v].b0);
            check($sformatf("v%0d nob_data0", v), int'(nob_data[0]), vecs[v].nd0);
            check($sformatf("v%0d nob_busy0", v), int'(nob_busy[0]), vecs[v].nb0);
            check($sformatf("v%0d byp_data1", v), int'(byp_data[1]), vecs[v].d12);
            check($sformatf("v%0d byp_data2", v), int'(byp_data[2]), vecs[v].d12);
            check($sformatf("v%0d byp_ready", v), int'(byp_ready), vecs[v].rdy);
            check($sformatf("v%0d nob_ready", v), int'(nob_ready), vecs[v].rdy);
            check($sformatf("v%0d byp_cnt", v), int'(byp_cnt), vecs[v].cnt);
            check($sformatf("v%0d nob_cnt", v), int'(nob_cnt), vecs[v].cnt);
            next_cycle();
        end

        // fill every non-zero register with a pending issue
        for (int i = 1; i < NR; i++) exp_q.push_back(CW'(i - 1));
        for (int i = 1; i < NR; i++) begin
            drive(0, 0, 0, 0, 1, i, i, i);
            #2;
            check($sformatf("fill%0d ready", i), int'(byp_ready), 1);
            check($sformatf("fill%0d cnt", i), int'(byp_cnt), int'(exp_q.pop_front()));
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 9, 31, 17);
        #2;
        check("full cnt", int'(byp_cnt), 31);
        check("full nob_cnt", int'(nob_cnt), 31);
        check("full busy31", int'(byp_busy[0]), 1);
        check("full busy17", int'(nob_busy[1]), 1);
        check("full ready9", int'(byp_ready), 0);
        next_cycle();

        // reset with a write and an issue pending in the same cycle
        drive(1, 1, 7, 123, 1, 7, 7, 3);
        #2;
        for (int p = 0; p < NP; p++) begin
            check($sformatf("rst byp_data%0d", p), int'(byp_data[p]), 0);
            check($sformatf("rst nob_data%0d", p), int'(nob_data[p]), 0);
            check($sformatf("rst byp_busy%0d", p), int'(byp_busy[p]), 0);
            check($sformatf("rst nob_busy%0d", p), int'(nob_busy[p]), 0);
        end
        check("rst byp_ready", int'(byp_ready), 0);
        check("rst nob_ready", int'(nob_ready), 0);
        check("rst byp_cnt", int'(byp_cnt), 0);
        check("rst nob_cnt", int'(nob_cnt), 0);
        next_cycle();

        // every register reads back cleared on both instances
        for (int k = 0; k < 11; k++) begin
            rst         = 1'b0;
            we          = 1'b0;
            issue_valid = 1'b0;
            issue_addr  = AW'(7);
            for (int p = 0; p < NP; p++) r_addr[p] = AW'((3 * k + p) % NR);
            #2;
            for (int p = 0; p < NP; p++) begin
                check($sformatf("post a%0d byp_data", int'(r_addr[p])), int'(byp_data[p]), 0);
                check($sformatf("post a%0d nob_data", int'(r_addr[p])), int'(nob_data[p]), 0);
                check($sformatf("post a%0d byp_busy", int'(r_addr[p])), int'(byp_busy[p]), 0);
            end
            check($sformatf("post%0d cnt", k), int'(byp_cnt), 0);
            check($sformatf("post%0d ready7", k), int'(byp_ready), 1);
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
